// File: rtl/debounce_edge_array.sv
// debounce_edge_array: per-channel synchroniser, glitch-reject FSM and edge/press pulse
// generation for push-buttons and switches, with optional auto-repeat while held.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_STABLE  | synchronised input matches o_level; repeat timer may run
// S_CONFIRM | input differs from o_level; counting ticks before committing
module debounce_edge_array #(
    parameter int N_CH           = 8,
    parameter int CLK_HZ         = 100_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int SYNC_STAGES    = 2,
    parameter int ACTIVE_HIGH    = 1,
    parameter int REPEAT_DELAY   = 0,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_in,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_press
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

    localparam logic            PRESSED    = (ACTIVE_HIGH != 0);
    localparam logic [N_CH-1:0] RELEASED_V = {N_CH{~PRESSED}};
    localparam bit              REPEAT_EN  = (REPEAT_DELAY > 0);

    typedef enum logic {
        S_STABLE  = 1'b0,
        S_CONFIRM = 1'b1
    } state_e;

    logic [PW-1:0]   pre_q;
    logic [PW-1:0]   pre_d;
    logic            tick;

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] s;

    state_e          state_q [N_CH];
    state_e          state_d [N_CH];
    logic [DW-1:0]   dcnt_q  [N_CH];
    logic [DW-1:0]   dcnt_d  [N_CH];
    logic [RW-1:0]   rcnt_q  [N_CH];
    logic [RW-1:0]   rcnt_d  [N_CH];

    // arm: repeats allowed (set by a press commit, cleared by any bounce)
    // rrun: first repeat already issued, later repeats use REPEAT_PERIOD
    logic [N_CH-1:0] arm_q, arm_d;
    logic [N_CH-1:0] rrun_q, rrun_d;
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [N_CH-1:0] press_q, press_d;

    // Shared tick prescaler: wraps every DIV cycles, tick marks the wrap cycle.
    always_comb begin
        tick  = (pre_q == PW'(DIV - 1));
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_q <= '0;
        else      pre_q <= pre_d;
    end

    // Input synchroniser, reset to the released level so no false edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RELEASED_V;
        end else begin
            sync_q[0] <= i_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Per-channel next state: glitch rejection, commit, and auto-repeat timing.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            dcnt_d[c]  = dcnt_q[c];
            rcnt_d[c]  = rcnt_q[c];
            arm_d[c]   = arm_q[c];
            rrun_d[c]  = rrun_q[c];
            level_d[c] = level_q[c];
            rise_d[c]  = 1'b0;
            fall_d[c]  = 1'b0;
            press_d[c] = 1'b0;
            case (state_q[c])
                S_STABLE: begin
                    if (s[c] != level_q[c]) begin
                        state_d[c] = S_CONFIRM;
                        dcnt_d[c]  = '0;
                        rcnt_d[c]  = '0;
                        arm_d[c]   = 1'b0;
                        rrun_d[c]  = 1'b0;
                    end else if (REPEAT_EN && arm_q[c] && (level_q[c] == PRESSED) && tick) begin
                        if (!rrun_q[c] && (rcnt_q[c] == RW'(REPEAT_DELAY - 1))) begin
                            press_d[c] = 1'b1;
                            rcnt_d[c]  = '0;
                            rrun_d[c]  = 1'b1;
                        end else if (rrun_q[c] && (rcnt_q[c] == RW'(REPEAT_PERIOD - 1))) begin
                            press_d[c] = 1'b1;
                            rcnt_d[c]  = '0;
                        end else begin
                            rcnt_d[c]  = rcnt_q[c] + RW'(1);
                        end
                    end
                end
                S_CONFIRM: begin
                    // A return to the committed level wins over a same-cycle tick.
                    if (s[c] == level_q[c]) begin
                        state_d[c] = S_STABLE;
                    end else if (tick) begin
                        if (dcnt_q[c] == DW'(DEBOUNCE_TICKS - 1)) begin
                            level_d[c] = ~level_q[c];
                            rise_d[c]  = ~level_q[c];
                            fall_d[c]  = level_q[c];
                            press_d[c] = ((~level_q[c]) == PRESSED);
                            arm_d[c]   = ((~level_q[c]) == PRESSED);
                            rrun_d[c]  = 1'b0;
                            rcnt_d[c]  = '0;
                            dcnt_d[c]  = '0;
                            state_d[c] = S_STABLE;
                        end else begin
                            dcnt_d[c]  = dcnt_q[c] + DW'(1);
                        end
                    end
                end
                default: begin
                    state_d[c] = S_STABLE;
                end
            endcase
        end
    end

    // Per-channel state, counters and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= S_STABLE;
                dcnt_q[c]  <= '0;
                rcnt_q[c]  <= '0;
            end
            arm_q   <= '0;
            rrun_q  <= '0;
            level_q <= RELEASED_V;
            rise_q  <= '0;
            fall_q  <= '0;
            press_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                dcnt_q[c]  <= dcnt_d[c];
                rcnt_q[c]  <= rcnt_d[c];
            end
            arm_q   <= arm_d;
            rrun_q  <= rrun_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_press = press_q;

endmodule

// File: tb/tb_debounce_edge_array.sv
// Testbench for debounce_edge_array: directed scenarios plus random toggling, every cycle
// compared against a behavioural model built from the debounce/repeat rules.
module tb_debounce_edge_array;

    localparam int N    = 4;
    localparam int CLKH = 1000;
    localparam int TKH  = 100;
    localparam int DIV  = CLKH / TKH;
    localparam int DT   = 3;
    localparam int SYNC = 2;
    localparam int AH   = 1;
    localparam int RD   = 5;
    localparam int RP   = 2;
    localparam logic PRESSED = (AH != 0);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] i_in = '0;
    logic [N-1:0] o_level, o_rise, o_fall, o_press;

    always #5 clk = ~clk;

    debounce_edge_array #(
        .N_CH(N), .CLK_HZ(CLKH), .TICK_HZ(TKH), .DEBOUNCE_TICKS(DT),
        .SYNC_STAGES(SYNC), .ACTIVE_HIGH(AH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .i_in(i_in),
        .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall), .o_press(o_press)
    );

    int checks = 0;
    int errors = 0;
    int gcyc   = 0;

    // behavioural model
    logic [N-1:0] hist [SYNC];
    int           m_cyc;
    logic [N-1:0] m_level, m_rise, m_fall, m_press;
    int           run_len [N];
    int           tk      [N];
    int           held    [N];
    bit           armed   [N];

    // observed statistics
    int rise_n [N];
    int fall_n [N];
    int press_n[N];
    int rise_at[N];
    int press_t[$];

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) hist[k] = {N{~PRESSED}};
        m_cyc   = 0;
        m_level = {N{~PRESSED}};
        m_rise  = '0;
        m_fall  = '0;
        m_press = '0;
        for (int c = 0; c < N; c++) begin
            run_len[c] = 0; tk[c] = 0; held[c] = 0; armed[c] = 0;
        end
    endtask

    // One clock edge: a level commits on the DT-th tick seen while the synchronised
    // input has kept differing (ticks in the cycle the difference first appears do not
    // count). Repeats fire DELAY ticks after a press commit, then every PERIOD ticks,
    // until the next disagreement between input and level.
    task automatic model_edge();
        logic [N-1:0] sv;
        bit           tick;
        logic [N-1:0] nl, nr, nf, np;
        sv   = hist[SYNC-1];
        tick = ((m_cyc % DIV) == DIV - 1);
        nl = m_level; nr = '0; nf = '0; np = '0;
        for (int c = 0; c < N; c++) begin
            if (sv[c] != m_level[c]) begin
                run_len[c]++;
                if (run_len[c] == 1) armed[c] = 0;
                else if (tick) tk[c]++;
                if (tk[c] == DT) begin
                    nl[c] = sv[c];
                    nr[c] = sv[c];
                    nf[c] = ~sv[c];
                    np[c] = (sv[c] == PRESSED);
                    armed[c] = (sv[c] == PRESSED);
                    held[c] = 0; run_len[c] = 0; tk[c] = 0;
                end
            end else begin
                run_len[c] = 0;
                tk[c] = 0;
                if (armed[c] && tick) begin
                    held[c]++;
                    if (held[c] == RD || (held[c] > RD && ((held[c] - RD) % RP) == 0)) np[c] = 1'b1;
                end
            end
        end
        m_level = nl; m_rise = nr; m_fall = nf; m_press = np;
        for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = i_in;
        m_cyc++;
    endtask

    task automatic check(input string tag);
        checks++;
        assert (o_level === m_level) else begin
            errors++; $error("FAIL %s level obs=%b exp=%b cyc=%0d", tag, o_level, m_level, gcyc);
        end
        checks++;
        assert (o_rise === m_rise) else begin
            errors++; $error("FAIL %s rise obs=%b exp=%b cyc=%0d", tag, o_rise, m_rise, gcyc);
        end
        checks++;
        assert (o_fall === m_fall) else begin
            errors++; $error("FAIL %s fall obs=%b exp=%b cyc=%0d", tag, o_fall, m_fall, gcyc);
        end
        checks++;
        assert (o_press === m_press) else begin
            errors++; $error("FAIL %s press obs=%b exp=%b cyc=%0d", tag, o_press, m_press, gcyc);
        end
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++; $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++; $error("FAIL %s obs=%0d exp=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic clr_stats();
        for (int c = 0; c < N; c++) begin
            rise_n[c] = 0; fall_n[c] = 0; press_n[c] = 0; rise_at[c] = -1000;
        end
        press_t.delete();
    endtask

    // Called at a negedge: drive, let one edge happen, compare, return at next negedge.
    task automatic step(input logic [N-1:0] din, input string tag);
        i_in = din;
        @(posedge clk);
        model_edge();
        gcyc++;
        #1;
        check(tag);
        for (int c = 0; c < N; c++) begin
            if (o_rise[c])  begin rise_n[c]++; rise_at[c] = gcyc; end
            if (o_fall[c])  fall_n[c]++;
            if (o_press[c]) press_n[c]++;
        end
        if (o_press[0]) press_t.push_back(gcyc);
        @(negedge clk);
    endtask

    task automatic run(input logic [N-1:0] din, input int n, input string tag);
        for (int k = 0; k < n; k++) step(din, tag);
    endtask

    // Asynchronous reset pulse in the middle of the low clock phase, held two cycles.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("reset_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int e;
        int pcnt;
        logic [N-1:0] rv;
        model_reset();
        clr_stats();
        @(negedge clk);
        #1;
        check("reset_init");
        @(negedge clk);
        rst = 1'b1;

        // 1: clean press on ch0
        clr_stats();
        e = gcyc + 1;
        run(4'b0001, 45, "t1_press");
        expect_int("t1_rise_cnt", rise_n[0], 1);
        expect_int("t1_press_cnt", press_n[0], 1);
        expect_rng("t1_latency", rise_at[0] - e + 1, 23, 33);
        expect_int("t1_others_idle", rise_n[1] + rise_n[2] + rise_n[3] + press_n[1] + press_n[2] + press_n[3], 0);
        run(4'b0001, 55, "t1_hold");
        run(4'b0000, 50, "t1_release");
        expect_int("t1_fall_cnt", fall_n[0], 1);

        // 2: glitch on ch1
        clr_stats();
        run(4'b0010, 15, "t2_glitch");
        run(4'b0000, 50, "t2_settle");
        expect_int("t2_pulses", rise_n[1] + fall_n[1] + press_n[1], 0);
        expect_int("t2_level", int'(o_level[1]), 0);

        // 3: bouncing ch2 then steady high
        clr_stats();
        for (int k = 0; k < 10; k++) run((k % 2 == 0) ? 4'b0100 : 4'b0000, 3, "t3_bounce");
        e = gcyc + 1;
        run(4'b0100, 45, "t3_steady");
        expect_int("t3_rise_cnt", rise_n[2], 1);
        expect_rng("t3_latency", rise_at[2] - e + 1, 23, 33);
        run(4'b0000, 50, "t3_release");

        // 4: auto-repeat on ch0
        clr_stats();
        run(4'b0001, 200, "t4_hold");
        expect_rng("t4_press_cnt", int'(press_t.size()), 6, 8);
        if (press_t.size() >= 3) begin
            expect_int("t4_first_at_commit", press_t[0], rise_at[0]);
            expect_int("t4_first_repeat", press_t[1] - press_t[0], 50);
            for (int k = 2; k < press_t.size(); k++)
                expect_int("t4_period", press_t[k] - press_t[k-1], 20);
        end
        pcnt = press_n[0];
        run(4'b0000, 60, "t4_release");
        expect_int("t4_fall_cnt", fall_n[0], 1);
        expect_int("t4_no_more_press", press_n[0], pcnt);

        // 5: simultaneous rise on ch0/ch3 with ch1 glitch
        clr_stats();
        run(4'b1001, 10, "t5_a");
        run(4'b1011, 5, "t5_glitch");
        run(4'b1001, 35, "t5_b");
        expect_int("t5_rise0", rise_n[0], 1);
        expect_int("t5_rise3", rise_n[3], 1);
        expect_int("t5_same_cycle", rise_at[0], rise_at[3]);
        expect_int("t5_ch1_quiet", rise_n[1] + fall_n[1] + press_n[1], 0);
        run(4'b0000, 50, "t5_release");

        // 6: reset while ch1 is confirming
        clr_stats();
        run(4'b0010, 15, "t6_confirm");
        do_reset();
        expect_int("t6_level_rst", int'(o_level), 0);
        expect_int("t6_pulses_rst", int'(o_rise | o_fall | o_press), 0);
        clr_stats();
        e = gcyc + 1;
        run(4'b0010, 40, "t6_after");
        expect_int("t6_rise_cnt", rise_n[1], 1);
        expect_rng("t6_full_debounce", rise_at[1] - e + 1, 23, 33);
        run(4'b0000, 50, "t6_release");

        // random phase: alternating bouncy and calm blocks, one mid-run reset
        rv = '0;
        for (int b = 0; b < 16; b++) begin
            if (b == 9) do_reset();
            for (int k = 0; k < 100; k++) begin
                for (int c = 0; c < N; c++)
                    if ($urandom_range((b % 2 == 0) ? 3 : 39, 0) == 0) rv[c] = ~rv[c];
                step(rv, "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
